bsg_mul_booth_4_iter_ctrl: RTL

- Sequential radix-4 Booth multiplier controller.
- Accepts one operand pair over a valid/ready handshake. Retires one Booth digit per cycle into an internal accumulator, then presents the 2*width_p product over a valid/yumi handshake.
- Exports each cycle's Booth digit encoding (S/D/N) so array-based multipliers can share the same encode/sequence logic and debug taps.
- Sits in front of area-constrained consumers (config/CSR math, address scaling) that cannot afford the full block-row array.

---
 rtl/bsg_mul_booth_4_iter_ctrl_if.sv | 37 +++
 rtl/bsg_mul_booth_4_iter_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bsg_mul_booth_4_iter_ctrl_if.sv
// Handshake bundle for the iterative radix-4 Booth multiplier controller.
//   master : producer/consumer side (drives operands and yumi_i)
//   slave  : controller side (drives ready/product/digit-debug outputs)
// Signals:
//   v_i, signed_i, a_i, b_i   operand handshake (valid/ready)
//   ready_o                   controller can accept operands
//   v_o, r_o, yumi_i          product handshake (valid/yumi)
//   sdn_v_o, sdn_o,           per-cycle Booth digit encoding {S,D,N}
//   digit_idx_o               and index of the digit being retired
interface bsg_mul_booth_4_iter_ctrl_if #(
   parameter int width_p = 16
);
   localparam int digits_lp = width_p/2 + 1;
   localparam int idx_w_lp  = $clog2(digits_lp);

   logic                   v_i;
   logic                   signed_i;
   logic [width_p-1:0]     a_i;
   logic [width_p-1:0]     b_i;
   logic                   ready_o;
   logic                   v_o;
   logic [2*width_p-1:0]   r_o;
   logic                   yumi_i;
   logic                   sdn_v_o;
   logic [2:0]             sdn_o;
   logic [idx_w_lp-1:0]    digit_idx_o;

   modport master (
      output v_i, signed_i, a_i, b_i, yumi_i,
      input  ready_o, v_o, r_o, sdn_v_o, sdn_o, digit_idx_o
   );

   modport slave (
      input  v_i, signed_i, a_i, b_i, yumi_i,
      output ready_o, v_o, r_o, sdn_v_o, sdn_o, digit_idx_o
   );
endinterface

// File: rtl/bsg_mul_booth_4_iter_ctrl.sv
// Sequential radix-4 Booth multiplier controller.
// Accepts one operand pair (valid/ready), retires one Booth digit per cycle
// into a 2*width_p accumulator, then offers the product (valid/yumi).
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   io       slave side of bsg_mul_booth_4_iter_ctrl_if (operands, product,
//            and the per-cycle digit encoding {S,D,N} with its index)
module bsg_mul_booth_4_iter_ctrl #(
   parameter int width_p = 16
) (
   input logic                          clk_i,
   input logic                          reset_i,
   bsg_mul_booth_4_iter_ctrl_if.slave   io
);
   localparam int digits_lp = width_p/2 + 1;
   localparam int idx_w_lp  = $clog2(digits_lp);
   localparam int ext_w_lp  = width_p + 2;
   localparam int acc_w_lp  = 2*width_p;

   if ((width_p < 4) || ((width_p % 2) != 0)) begin : g_bad_width
      $error("bsg_mul_booth_4_iter_ctrl: width_p must be even and >= 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic                   v_q, v_d;
   logic                   sdn_v_q, sdn_v_d;
   logic [2:0]             sdn_q, sdn_d;
   logic [idx_w_lp-1:0]    idx_q, idx_d;
   logic [acc_w_lp-1:0]    acc_q, acc_d;
   // multiplicand pre-shifted by 2*idx, so the current digit weight is implicit
   logic [acc_w_lp-1:0]    m_q, m_d;
   // extended multiplier with the implicit bit -1 appended; bits [2:0] are
   // always the triplet of the digit about to be retired
   logic [ext_w_lp:0]      b_sh_q, b_sh_d;

   logic [ext_w_lp-1:0]    a_ext, b_ext;
   logic [acc_w_lp-1:0]    pp;

   // triplet {b(2i+1), b(2i), b(2i-1)} -> {S,D,N}
   function automatic logic [2:0] booth_sdn(input logic [2:0] t);
      logic s, d, n;
      s = t[2] & ~(t[1] & t[0]);
      d = (t[2] & ~t[1] & ~t[0]) | (~t[2] & t[1] & t[0]);
      n = ~((t[2] == t[1]) && (t[1] == t[0]));
      return {s, d, n};
   endfunction

   always_comb begin
      a_ext   = io.signed_i ? {{2{io.a_i[width_p-1]}}, io.a_i} : {2'b00, io.a_i};
      b_ext   = io.signed_i ? {{2{io.b_i[width_p-1]}}, io.b_i} : {2'b00, io.b_i};
      pp      = sdn_q[1] ? (m_q << 1) : m_q;

      state_d = state_q;
      ready_d = ready_q;
      v_d     = v_q;
      sdn_v_d = sdn_v_q;
      sdn_d   = sdn_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      m_d     = m_q;
      b_sh_d  = b_sh_q;

      case (state_q)
         IDLE: begin
            if (io.v_i) begin
               state_d = BUSY;
               ready_d = 1'b0;
               sdn_v_d = 1'b1;
               idx_d   = '0;
               acc_d   = '0;
               m_d     = {{(acc_w_lp-ext_w_lp){a_ext[ext_w_lp-1]}}, a_ext};
               b_sh_d  = {b_ext, 1'b0};
               sdn_d   = booth_sdn(b_sh_d[2:0]);
            end
         end
         BUSY: begin
            // modular 2*width_p arithmetic yields the exact product in both modes
            if (sdn_q[0]) begin
               acc_d = sdn_q[2] ? (acc_q - pp) : (acc_q + pp);
            end
            m_d    = m_q << 2;
            b_sh_d = b_sh_q >> 2;
            if (idx_q == idx_w_lp'(digits_lp-1)) begin
               state_d = DONE;
               sdn_v_d = 1'b0;
               v_d     = 1'b1;
               idx_d   = '0;
               sdn_d   = '0;
            end else begin
               idx_d = idx_q + idx_w_lp'(1);
               sdn_d = booth_sdn(b_sh_d[2:0]);
            end
         end
         DONE: begin
            if (io.yumi_i) begin
               state_d = IDLE;
               v_d     = 1'b0;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            v_d     = 1'b0;
            sdn_v_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         v_q     <= 1'b0;
         sdn_v_q <= 1'b0;
         sdn_q   <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         b_sh_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         v_q     <= v_d;
         sdn_v_q <= sdn_v_d;
         sdn_q   <= sdn_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         b_sh_q  <= b_sh_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(io.yumi_i && !v_q))
            else $error("bsg_mul_booth_4_iter_ctrl: yumi_i asserted while v_o is low");
      end
   end

   assign io.ready_o     = ready_q;
   assign io.v_o         = v_q;
   assign io.r_o         = acc_q;
   assign io.sdn_v_o     = sdn_v_q;
   assign io.sdn_o       = sdn_q;
   assign io.digit_idx_o = idx_q;
endmodule
